mem_arbiter: RTL and testbench

Single-ported word-memory arbiter sharing the unified CPU memory between three requesters: instruction fetch (port 0), data load/store (port 1) and a debug/loader port (port 2). The arbiter sits between the CPU's fetch/memory stages and the `cpumem` word array:
- `.text` occupies word 0 upward.
- `.data` starts at word 2048 (byte 0x2000).

It issues at most one memory command per cycle and returns read data one cycle after grant. A per-port starvation counter bounds the wait of every port.

---
 rtl/mem_arb_pkg.sv | 39 +++
 rtl/mem_arb_pick.sv | 72 +++++++
 rtl/mem_arbiter.sv | 229 ++++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// ----------------------------------------------------------------------------
// mem_arb_pkg
//
// Shared definitions for the unified-memory arbiter:
//   - port index constants (fetch, data, debug/loader)
//   - read-return tag encoding, TAG_NONE meaning "no read in flight"
//   - memory map anchors for .text and .data (word addresses)
//   - wait-counter width and the round-robin pointer reset value
//   - port_next(): modulo-3 successor used by the round-robin search
// ----------------------------------------------------------------------------
package mem_arb_pkg;

    localparam int unsigned NUM_PORTS = 3;

    localparam logic [1:0] PORT_IF  = 2'd0;
    localparam logic [1:0] PORT_DM  = 2'd1;
    localparam logic [1:0] PORT_DBG = 2'd2;

    typedef enum logic [1:0] {
        TAG_IF   = 2'd0,
        TAG_DM   = 2'd1,
        TAG_DBG  = 2'd2,
        TAG_NONE = 2'd3
    } mem_arb_tag_e;

    // Word addresses: .text from word 0, .data from byte 0x2000.
    localparam int unsigned TEXT_BASE = 0;
    localparam int unsigned DATA_BASE = 2048;

    localparam int unsigned WAIT_W = 3;

    // Pointer "last granted = debug" so the first round-robin search starts at fetch.
    localparam logic [1:0] PTR_RESET = PORT_DBG;

    function automatic logic [1:0] port_next(input logic [1:0] p);
        return (p >= PORT_DBG) ? PORT_IF : p + 2'd1;
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// ----------------------------------------------------------------------------
// mem_arb_pick
//
// Purely combinational winner selection for the three-port memory arbiter.
//   1. Any requesting port whose wait counter is saturated (starved) wins,
//      lowest index first.
//   2. Otherwise the base policy applies:
//        MEM_ARB_RR_EN defined   : round-robin, search starts at ptr_i + 1 (mod 3)
//        MEM_ARB_RR_EN undefined : fixed priority, data > fetch > debug
//
// Ports:
//   req_i     [2:0]  request vector, bit index = port index
//   starved_i [2:0]  starvation flags from the wait counters
//   ptr_i     [1:0]  last granted port (round-robin build only)
//   gnt_o     [2:0]  one-hot grant, zero when nothing requests
// ----------------------------------------------------------------------------
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic [NUM_PORTS-1:0] starved_i,
`ifdef MEM_ARB_RR_EN
    input  logic [1:0]           ptr_i,
`endif
    output logic [NUM_PORTS-1:0] gnt_o
);

    logic [NUM_PORTS-1:0] starved_req;

    assign starved_req = req_i & starved_i;

`ifdef MEM_ARB_RR_EN
    // Candidate search order for this cycle.
    logic [1:0] cand0;
    logic [1:0] cand1;
    logic [1:0] cand2;

    assign cand0 = port_next(ptr_i);
    assign cand1 = port_next(cand0);
    assign cand2 = port_next(cand1);
`endif

    always_comb begin
        gnt_o = '0;
        if (starved_req[PORT_IF]) begin
            gnt_o[PORT_IF] = 1'b1;
        end else if (starved_req[PORT_DM]) begin
            gnt_o[PORT_DM] = 1'b1;
        end else if (starved_req[PORT_DBG]) begin
            gnt_o[PORT_DBG] = 1'b1;
        end else begin
`ifdef MEM_ARB_RR_EN
            if (req_i[cand0]) begin
                gnt_o[cand0] = 1'b1;
            end else if (req_i[cand1]) begin
                gnt_o[cand1] = 1'b1;
            end else if (req_i[cand2]) begin
                gnt_o[cand2] = 1'b1;
            end
`else
            if (req_i[PORT_DM]) begin
                gnt_o[PORT_DM] = 1'b1;
            end else if (req_i[PORT_IF]) begin
                gnt_o[PORT_IF] = 1'b1;
            end else if (req_i[PORT_DBG]) begin
                gnt_o[PORT_DBG] = 1'b1;
            end
`endif
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// ----------------------------------------------------------------------------
// mem_arbiter
//
// Single-ported word-memory arbiter sharing the unified CPU memory between
// instruction fetch (port 0), data load/store (port 1) and debug/loader
// (port 2). At most one memory command per cycle; read data returns one
// cycle after the grant together with a one-cycle rvalid on the owning port.
// A 3-bit wait counter per port bounds every port's wait: once a counter
// saturates at MAX_WAIT that port overrides the base policy.
//
// Build option: MEM_ARB_RR_EN selects a round-robin base policy (pointer
// register built); otherwise fixed priority data > fetch > debug.
//
// Parameters: ADDR_W (word address width), DATA_W, MAX_WAIT.
//
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   if_req_i/if_addr_i            fetch requester (read-only)
//   dm_req_i/dm_addr_i/dm_we_i/dm_wdata_i      data requester
//   dbg_req_i/dbg_addr_i/dbg_we_i/dbg_wdata_i  debug/loader requester
//   *_gnt_o                       combinational grants, one-hot or zero
//   *_rvalid_o                    read-return strobes, one cycle after gnt
//   rdata_o                       shared read data, qualified by rvalid
//   mem_en_o/mem_we_o/mem_addr_o/mem_wdata_o   memory command
//   mem_rdata_i                   memory read data, valid the cycle after a read
// ----------------------------------------------------------------------------
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W   = 12,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MAX_WAIT = 7
) (
    input  logic              clk_i,
    input  logic              rst_ni,

    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,

    input  logic              dm_req_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic              dm_we_i,
    input  logic [DATA_W-1:0] dm_wdata_i,

    input  logic              dbg_req_i,
    input  logic [ADDR_W-1:0] dbg_addr_i,
    input  logic              dbg_we_i,
    input  logic [DATA_W-1:0] dbg_wdata_i,

    output logic              if_gnt_o,
    output logic              dm_gnt_o,
    output logic              dbg_gnt_o,

    output logic              if_rvalid_o,
    output logic              dm_rvalid_o,
    output logic              dbg_rvalid_o,
    output logic [DATA_W-1:0] rdata_o,

    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    localparam logic [WAIT_W-1:0] MaxWaitCnt = WAIT_W'(MAX_WAIT);

    logic [NUM_PORTS-1:0] req;
    logic [NUM_PORTS-1:0] starved;
    logic [NUM_PORTS-1:0] pick_gnt;
    logic [NUM_PORTS-1:0] gnt;

    logic [WAIT_W-1:0]    wait_q [NUM_PORTS];
    logic [WAIT_W-1:0]    wait_d [NUM_PORTS];

    mem_arb_tag_e         tag_q;
    mem_arb_tag_e         tag_d;
    logic [DATA_W-1:0]    rdata_q;
    logic                 rvalid_any;

    assign req = {dbg_req_i, dm_req_i, if_req_i};

    always_comb begin
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            starved[i] = (wait_q[i] == MaxWaitCnt);
        end
    end

    // ------------------------------------------------------------------
    // Round-robin pointer (last granted port)
    // ------------------------------------------------------------------
`ifdef MEM_ARB_RR_EN
    logic [1:0] ptr_q;
    logic [1:0] ptr_d;

    // Starvation grants move the pointer too, so the overridden port is
    // not favoured again right after it was served.
    always_comb begin
        ptr_d = ptr_q;
        unique case (gnt)
            3'b001:  ptr_d = PORT_IF;
            3'b010:  ptr_d = PORT_DM;
            3'b100:  ptr_d = PORT_DBG;
            default: ptr_d = ptr_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= PTR_RESET;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Winner selection
    // ------------------------------------------------------------------
    mem_arb_pick u_pick (
        .req_i     (req),
        .starved_i (starved),
`ifdef MEM_ARB_RR_EN
        .ptr_i     (ptr_q),
`endif
        .gnt_o     (pick_gnt)
    );

    // No command may leave while reset is held, even with requests pending.
    assign gnt = rst_ni ? pick_gnt : '0;

    assign if_gnt_o  = gnt[PORT_IF];
    assign dm_gnt_o  = gnt[PORT_DM];
    assign dbg_gnt_o = gnt[PORT_DBG];

    // ------------------------------------------------------------------
    // Memory command mux
    // ------------------------------------------------------------------
    assign mem_en_o = |gnt;

    always_comb begin
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        unique case (gnt)
            3'b001: begin
                mem_addr_o  = if_addr_i;
            end
            3'b010: begin
                mem_we_o    = dm_we_i;
                mem_addr_o  = dm_addr_i;
                mem_wdata_o = dm_wdata_i;
            end
            3'b100: begin
                mem_we_o    = dbg_we_i;
                mem_addr_o  = dbg_addr_i;
                mem_wdata_o = dbg_wdata_i;
            end
            default: begin
                mem_we_o    = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Wait counters
    // ------------------------------------------------------------------
    always_comb begin
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (!req[i] || gnt[i]) begin
                wait_d[i] = '0;
            end else if (!starved[i]) begin
                wait_d[i] = wait_q[i] + 1'b1;
            end else begin
                wait_d[i] = wait_q[i];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                wait_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                wait_q[i] <= wait_d[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Read-return tracking
    // ------------------------------------------------------------------
    always_comb begin
        tag_d = TAG_NONE;
        if (gnt[PORT_IF]) begin
            tag_d = TAG_IF;
        end else if (gnt[PORT_DM] && !dm_we_i) begin
            tag_d = TAG_DM;
        end else if (gnt[PORT_DBG] && !dbg_we_i) begin
            tag_d = TAG_DBG;
        end
    end

    // rdata_q keeps the last returned word so rdata_o stays stable between
    // returns; reset clears it and the tag, dropping any in-flight read.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tag_q   <= TAG_NONE;
            rdata_q <= '0;
        end else begin
            tag_q <= tag_d;
            if (rvalid_any) begin
                rdata_q <= mem_rdata_i;
            end
        end
    end

    assign rvalid_any   = (tag_q != TAG_NONE);
    assign if_rvalid_o  = (tag_q == TAG_IF);
    assign dm_rvalid_o  = (tag_q == TAG_DM);
    assign dbg_rvalid_o = (tag_q == TAG_DBG);

    // The memory's own output register supplies the word in the return
    // cycle, which keeps the read latency at one cycle after grant.
    assign rdata_o = rvalid_any ? mem_rdata_i : rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Directed self-checking bench for mem_arbiter with a synchronous-read word
// memory model. Works for both the fixed-priority build and the
// MEM_ARB_RR_EN round-robin build.
// ----------------------------------------------------------------------------
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        if_req;
    logic [11:0] if_addr;
    logic        dm_req;
    logic [11:0] dm_addr;
    logic        dm_we;
    logic [31:0] dm_wdata;
    logic        dbg_req;
    logic [11:0] dbg_addr;
    logic        dbg_we;
    logic [31:0] dbg_wdata;
    logic        if_gnt, dm_gnt, dbg_gnt;
    logic        if_rvalid, dm_rvalid, dbg_rvalid;
    logic [31:0] rdata;
    logic        mem_en, mem_we;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [2:0]  gnt_v;
    logic [2:0]  rv_v;

    int total = 0;
    int bad   = 0;

    localparam logic [31:0] TextWord = 32'h2008_0005;
    localparam logic [31:0] DataWord = 32'hDEAD_BEEF;
    localparam logic [11:0] TextAddr = 12'(TEXT_BASE);
    localparam logic [11:0] DataAddr = 12'(DATA_BASE);

    assign gnt_v = {dbg_gnt, dm_gnt, if_gnt};
    assign rv_v  = {dbg_rvalid, dm_rvalid, if_rvalid};

    mem_arbiter dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .if_req_i     (if_req),
        .if_addr_i    (if_addr),
        .dm_req_i     (dm_req),
        .dm_addr_i    (dm_addr),
        .dm_we_i      (dm_we),
        .dm_wdata_i   (dm_wdata),
        .dbg_req_i    (dbg_req),
        .dbg_addr_i   (dbg_addr),
        .dbg_we_i     (dbg_we),
        .dbg_wdata_i  (dbg_wdata),
        .if_gnt_o     (if_gnt),
        .dm_gnt_o     (dm_gnt),
        .dbg_gnt_o    (dbg_gnt),
        .if_rvalid_o  (if_rvalid),
        .dm_rvalid_o  (dm_rvalid),
        .dbg_rvalid_o (dbg_rvalid),
        .rdata_o      (rdata),
        .mem_en_o     (mem_en),
        .mem_we_o     (mem_we),
        .mem_addr_o   (mem_addr),
        .mem_wdata_o  (mem_wdata),
        .mem_rdata_i  (mem_rdata)
    );

    // Synchronous-read memory: read word appears the cycle after the command.
    logic [31:0] mem [4096];
    logic [31:0] mem_q;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_q <= mem[mem_addr];
        end
    end
    assign mem_rdata = mem_q;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic idle_inputs;
        if_req = 1'b0; dm_req = 1'b0; dbg_req = 1'b0;
        dm_we = 1'b0; dbg_we = 1'b0;
    endtask

    task automatic do_reset;
        @(posedge clk); #1;
        idle_inputs();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        logic [2:0] first;
`ifdef MEM_ARB_RR_EN
        first = 3'b001;
`else
        first = 3'b010;
`endif
        rst_n = 1'b0;
        if_req = 1'b1; dm_req = 1'b1; dbg_req = 1'b1;
        if_addr = TextAddr; dm_addr = DataAddr; dbg_addr = TextAddr;
        @(negedge clk);
        total++;
        if (gnt_v !== 3'b000) begin
            bad++; $display("FAIL reset_gnt got=%b exp=000", gnt_v);
        end
        total++;
        if (mem_en !== 1'b0) begin
            bad++; $display("FAIL reset_mem_en got=%b exp=0", mem_en);
        end
        total++;
        if (rv_v !== 3'b000 || rdata !== 32'h0) begin
            bad++; $display("FAIL reset_rvalid got=%b/%h exp=000/0", rv_v, rdata);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (gnt_v !== first) begin
            bad++; $display("FAIL first_grant got=%b exp=%b", gnt_v, first);
        end
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        total++;
        if (rv_v !== first) begin
            bad++; $display("FAIL first_rvalid got=%b exp=%b", rv_v, first);
        end
        @(posedge clk); #1;
        @(negedge clk);
        total++;
        if (rv_v !== 3'b000) begin
            bad++; $display("FAIL first_rvalid_once got=%b exp=000", rv_v);
        end
    endtask

    // Loader writes the fetch word through the debug port.
    task automatic test_dbg_write;
        @(posedge clk); #1;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = TextAddr; dbg_wdata = TextWord;
        @(negedge clk);
        total++;
        if (gnt_v !== 3'b100 || mem_we !== 1'b1 || mem_addr !== TextAddr
            || mem_wdata !== TextWord) begin
            bad++; $display("FAIL dbg_write_cmd got=%b/%b/%h/%h exp=100/1/%h/%h",
                            gnt_v, mem_we, mem_addr, mem_wdata, TextAddr, TextWord);
        end
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        total++;
        if (rv_v !== 3'b000) begin
            bad++; $display("FAIL dbg_write_no_rvalid got=%b exp=000", rv_v);
        end
    endtask

    task automatic test_fetch;
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = TextAddr;
        @(negedge clk);
        total++;
        if (gnt_v !== 3'b001 || mem_en !== 1'b1 || mem_we !== 1'b0) begin
            bad++; $display("FAIL fetch_gnt got=%b/%b/%b exp=001/1/0", gnt_v, mem_en, mem_we);
        end
        @(posedge clk); #1;
        if_req = 1'b0;
        @(negedge clk);
        total++;
        if (rv_v !== 3'b001 || rdata !== TextWord) begin
            bad++; $display("FAIL fetch_return got=%b/%h exp=001/%h", rv_v, rdata, TextWord);
        end
        total++;
        if (mem_en !== 1'b0) begin
            bad++; $display("FAIL fetch_idle_mem_en got=%b exp=0", mem_en);
        end
        @(posedge clk); #1;
        @(negedge clk);
        total++;
        if (rv_v !== 3'b000) begin
            bad++; $display("FAIL fetch_rvalid_once got=%b exp=000", rv_v);
        end
    endtask

    // Write then read of the same .data word, back-to-back.
    task automatic test_dm_write_read;
        @(posedge clk); #1;
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = DataAddr; dm_wdata = DataWord;
        @(negedge clk);
        total++;
        if (gnt_v !== 3'b010 || mem_we !== 1'b1 || mem_wdata !== DataWord) begin
            bad++; $display("FAIL dm_write_cmd got=%b/%b/%h exp=010/1/%h",
                            gnt_v, mem_we, mem_wdata, DataWord);
        end
        @(posedge clk); #1;
        dm_we = 1'b0;
        @(negedge clk);
        total++;
        if (gnt_v !== 3'b010 || mem_we !== 1'b0 || rv_v !== 3'b000) begin
            bad++; $display("FAIL dm_read_cmd got=%b/%b/%b exp=010/0/000", gnt_v, mem_we, rv_v);
        end
        @(posedge clk); #1;
        dm_req = 1'b0;
        @(negedge clk);
        total++;
        if (rv_v !== 3'b010 || rdata !== DataWord) begin
            bad++; $display("FAIL dm_read_return got=%b/%h exp=010/%h", rv_v, rdata, DataWord);
        end
        @(posedge clk); #1;
        @(negedge clk);
        total++;
        if (rv_v !== 3'b000 || rdata !== DataWord) begin
            bad++; $display("FAIL dm_rdata_hold got=%b/%h exp=000/%h", rv_v, rdata, DataWord);
        end
    endtask

`ifndef MEM_ARB_RR_EN
    task automatic test_priority;
        do_reset();
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = TextAddr; dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = TextAddr;
        @(negedge clk);
        total++;
        if (gnt_v !== 3'b001) begin
            bad++; $display("FAIL prio_if_over_dbg got=%b exp=001", gnt_v);
        end
        @(posedge clk); #1;
        idle_inputs();
        @(posedge clk); #1;
    endtask

    // Data port hogs; fetch is denied 7 cycles and wins on the 8th.
    task automatic test_starvation;
        logic [2:0]  exp;
        logic [2:0]  prev;
        logic [31:0] exp_data;
        do_reset();
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = TextAddr;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = DataAddr;
        prev = 3'b000;
        for (int c = 1; c <= 11; c++) begin
            exp = (c == 8) ? 3'b001 : 3'b010;
            @(negedge clk);
            total++;
            if (gnt_v !== exp) begin
                bad++; $display("FAIL starve_gnt cycle=%0d got=%b exp=%b", c, gnt_v, exp);
            end
            total++;
            if (rv_v !== prev) begin
                bad++; $display("FAIL starve_rvalid cycle=%0d got=%b exp=%b", c, rv_v, prev);
            end
            if (prev != 3'b000) begin
                exp_data = (prev == 3'b001) ? TextWord : DataWord;
                total++;
                if (rdata !== exp_data) begin
                    bad++; $display("FAIL starve_rdata cycle=%0d got=%h exp=%h", c, rdata, exp_data);
                end
            end
            prev = exp;
            @(posedge clk); #1;
        end
        idle_inputs();
    endtask
`else
    // All three requesting: strict rotation, rvalid one cycle behind.
    task automatic test_round_robin;
        logic [2:0]  exp;
        logic [2:0]  prev;
        logic [31:0] exp_data;
        do_reset();
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = TextAddr;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = DataAddr;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = TextAddr;
        prev = 3'b000;
        for (int c = 0; c < 7; c++) begin
            exp = 3'b001 << (c % 3);
            @(negedge clk);
            total++;
            if (gnt_v !== exp) begin
                bad++; $display("FAIL rr_gnt cycle=%0d got=%b exp=%b", c, gnt_v, exp);
            end
            total++;
            if (rv_v !== prev) begin
                bad++; $display("FAIL rr_rvalid cycle=%0d got=%b exp=%b", c, rv_v, prev);
            end
            if (prev != 3'b000) begin
                exp_data = (prev == 3'b010) ? DataWord : TextWord;
                total++;
                if (rdata !== exp_data) begin
                    bad++; $display("FAIL rr_rdata cycle=%0d got=%h exp=%h", c, rdata, exp_data);
                end
            end
            prev = exp;
            @(posedge clk); #1;
        end
        idle_inputs();
    endtask
`endif

    // Read granted, then reset asserted early in the return cycle.
    task automatic test_reset_mid;
        @(posedge clk); #1;
        idle_inputs();
        if_req = 1'b1; if_addr = TextAddr;
        @(negedge clk);
        total++;
        if (gnt_v !== 3'b001) begin
            bad++; $display("FAIL mid_gnt got=%b exp=001", gnt_v);
        end
        @(posedge clk); #1;
        if_req = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        total++;
        if (rv_v !== 3'b000 || rdata !== 32'h0) begin
            bad++; $display("FAIL mid_in_reset got=%b/%h exp=000/0", rv_v, rdata);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            total++;
            if (rv_v !== 3'b000 || rdata !== 32'h0) begin
                bad++; $display("FAIL mid_after_release cycle=%0d got=%b/%h exp=000/0",
                                c, rv_v, rdata);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst_n = 1'b1;
        idle_inputs();
        if_addr = '0; dm_addr = '0; dbg_addr = '0;
        dm_wdata = '0; dbg_wdata = '0;
        #2;
        test_reset();
        test_dbg_write();
        test_fetch();
        test_dm_write_read();
`ifndef MEM_ARB_RR_EN
        test_priority();
        test_starvation();
`else
        test_round_robin();
`endif
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
